knight_cmd_proc: RTL

- Command processor downstream of the tour command sequencer.
- Consumes 16-bit move/calibrate commands over the cmd/cmd_rdy/clr_cmd_rdy handshake.
- Drives desired heading and a ramped forward speed to the motion controller, and counts board lines crossed.
- Signals completion back to the sequencer with send_resp; that response gates issue of the next command.

---
 rtl/knight_cmd_proc.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/knight_cmd_proc.sv
// Knight command processor: decodes move/calibrate commands, steers the heading,
// ramps forward speed and counts board lines until the move is complete.
module knight_cmd_proc #(
    parameter bit          FAST_SIM  = 1'b1,
    parameter logic [9:0]  MAX_FRWRD = 10'h2A0,
    parameter logic [11:0] HDG_TOL   = 12'h02C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        strt_cal,
    input  logic        cal_done,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic [11:0] dsrd_hdg,
    output logic [9:0]  frwrd,
    output logic        moving,
    output logic        fanfare_go
);

    localparam logic [9:0]  FRWRD_INC = FAST_SIM ? 10'h020 : 10'h004;
    localparam logic [10:0] DEC_STEP  = {FRWRD_INC, 1'b0};

    typedef enum logic [2:0] {IDLE, CAL, TURN, ACCEL, DECEL} state_t;

    state_t      state_q, state_d;
    logic [11:0] dsrd_hdg_q, dsrd_hdg_d;
    logic [9:0]  frwrd_q, frwrd_d;
    logic        moving_q, moving_d;
    logic [4:0]  sq_tgt_q, sq_tgt_d;
    logic [4:0]  lines_q, lines_d;
    logic        fanfare_q, fanfare_d;
    logic        cntr_ir_q;

    logic [3:0]  opcode;
    logic        ir_rise;
    logic [4:0]  lines_now;
    logic [11:0] hdg_err;
    logic [11:0] hdg_err_abs;
    logic [10:0] frwrd_inc_sum;

    assign opcode        = cmd[15:12];
    assign ir_rise       = cntrIR & ~cntr_ir_q;
    assign lines_now     = lines_q + {4'b0000, ir_rise};
    assign hdg_err       = heading - dsrd_hdg_q;
    // Negating 12'h800 yields 12'h800 again, which reads as the largest error.
    assign hdg_err_abs   = hdg_err[11] ? (~hdg_err + 12'd1) : hdg_err;
    assign frwrd_inc_sum = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};

    always_comb begin
        state_d     = state_q;
        dsrd_hdg_d  = dsrd_hdg_q;
        frwrd_d     = frwrd_q;
        moving_d    = moving_q;
        sq_tgt_d    = sq_tgt_q;
        fanfare_d   = fanfare_q;
        lines_d     = lines_q;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        strt_cal    = 1'b0;
        fanfare_go  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    lines_d     = '0;
                    if (opcode == 4'h0) begin
                        strt_cal = 1'b1;
                        state_d  = CAL;
                    end else if (opcode == 4'h2 || opcode == 4'h3) begin
                        dsrd_hdg_d = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
                        sq_tgt_d   = {cmd[3:0], 1'b0};
                        fanfare_d  = cmd[12];
                        moving_d   = 1'b1;
                        state_d    = TURN;
                    end
                end
            end
            CAL: begin
                if (cal_done) begin
                    send_resp = 1'b1;
                    state_d   = IDLE;
                end
            end
            TURN: begin
                frwrd_d = '0;
                if (heading_rdy && (hdg_err_abs < HDG_TOL)) begin
                    state_d = (sq_tgt_q == 5'd0) ? DECEL : ACCEL;
                end
            end
            ACCEL: begin
                lines_d = lines_now;
                // Reaching the final line takes priority over a same-cycle speed step.
                if (lines_now == sq_tgt_q) begin
                    fanfare_go = fanfare_q;
                    state_d    = DECEL;
                end else if (heading_rdy) begin
                    frwrd_d = (frwrd_inc_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : frwrd_inc_sum[9:0];
                end
            end
            DECEL: begin
                if (frwrd_q == '0) begin
                    moving_d  = 1'b0;
                    send_resp = 1'b1;
                    state_d   = IDLE;
                end else if (heading_rdy) begin
                    frwrd_d = ({1'b0, frwrd_q} <= DEC_STEP) ? '0 : (frwrd_q - DEC_STEP[9:0]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dsrd_hdg_q <= '0;
            frwrd_q    <= '0;
            moving_q   <= 1'b0;
            sq_tgt_q   <= '0;
            lines_q    <= '0;
            fanfare_q  <= 1'b0;
            cntr_ir_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dsrd_hdg_q <= dsrd_hdg_d;
            frwrd_q    <= frwrd_d;
            moving_q   <= moving_d;
            sq_tgt_q   <= sq_tgt_d;
            lines_q    <= lines_d;
            fanfare_q  <= fanfare_d;
            cntr_ir_q  <= cntrIR;
        end
    end

    assign dsrd_hdg = dsrd_hdg_q;
    assign frwrd    = frwrd_q;
    assign moving   = moving_q;

endmodule
